// File: rtl/seg_disp_ctrl.sv
// Six-digit time/date display sequencer: auto-pages between time and date,
// and blinks the field under edit by blanking it on alternate half-periods.
module seg_disp_ctrl #(
  parameter int unsigned PAGE_CYCLES  = 250_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_bcd,
  input  logic        time_vld,
  input  logic [23:0] date_bcd,
  input  logic        date_vld,
  input  logic        edit_en,
  input  logic        edit_page,
  input  logic [1:0]  edit_field,
  output logic [23:0] seg_bcd,
  output logic        page,
  output logic        blink_on
);

  localparam int PW = (PAGE_CYCLES  > 1) ? $clog2(PAGE_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_TIME = 2'd0,
    SHOW_DATE = 2'd1,
    EDIT      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] page_cnt_q, page_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;   // 1 = selected field blanked
  logic [23:0] time_q, date_q;
  logic [1:0]  field_prev_q;
  logic        page_prev_q;
  logic [23:0] seg_bcd_q, seg_bcd_d;
  logic        page_q, page_d;
  logic        blink_on_q, blink_on_d;
  logic        restart;
  logic        blank;
  logic [23:0] src;

  // Edit selection changed since last cycle: blink restarts from the visible phase.
  assign restart = (state_q == EDIT) &&
                   ((edit_field != field_prev_q) || (edit_page != page_prev_q));

  always_comb begin
    state_d     = state_q;
    page_cnt_d  = page_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    case (state_q)
      SHOW_TIME, SHOW_DATE: begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (edit_en) begin
          state_d    = EDIT;
          page_cnt_d = '0;
        end else if (page_cnt_q == PAGE_LAST) begin
          state_d    = (state_q == SHOW_TIME) ? SHOW_DATE : SHOW_TIME;
          page_cnt_d = '0;
        end else begin
          page_cnt_d = page_cnt_q + 1'b1;
        end
      end
      EDIT: begin
        page_cnt_d = '0;
        if (!edit_en) begin
          state_d     = edit_page ? SHOW_DATE : SHOW_TIME;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (restart) begin
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = SHOW_TIME;
        page_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end
    endcase
  end

  // A restart cycle is shown visible so a field change never flashes the new field blank.
  always_comb begin
    page_d     = (state_q == SHOW_DATE) || ((state_q == EDIT) && edit_page);
    src        = page_d ? date_q : time_q;
    blank      = (state_q == EDIT) && phase_q && (edit_field != 2'd3) && !restart;
    blink_on_d = blank;
    seg_bcd_d  = src;
    if (blank) begin
      case (edit_field)
        2'd0:    seg_bcd_d[23:16] = {BLANK_CODE, BLANK_CODE};
        2'd1:    seg_bcd_d[15:8]  = {BLANK_CODE, BLANK_CODE};
        2'd2:    seg_bcd_d[7:0]   = {BLANK_CODE, BLANK_CODE};
        default: seg_bcd_d        = src;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW_TIME;
      page_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      time_q       <= 24'h000000;
      date_q       <= 24'h000000;
      field_prev_q <= 2'd0;
      page_prev_q  <= 1'b0;
      seg_bcd_q    <= 24'h000000;
      page_q       <= 1'b0;
      blink_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_cnt_q   <= page_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      if (time_vld) time_q <= time_bcd;
      if (date_vld) date_q <= date_bcd;
      field_prev_q <= edit_field;
      page_prev_q  <= edit_page;
      seg_bcd_q    <= seg_bcd_d;
      page_q       <= page_d;
      blink_on_q   <= blink_on_d;
    end
  end

  assign seg_bcd  = seg_bcd_q;
  assign page     = page_q;
  assign blink_on = blink_on_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl with short page/blink periods.
module tb_seg_disp_ctrl;

  logic        clk;
  logic        rst;
  logic [23:0] time_bcd;
  logic        time_vld;
  logic [23:0] date_bcd;
  logic        date_vld;
  logic        edit_en;
  logic        edit_page;
  logic [1:0]  edit_field;
  logic [23:0] seg_bcd;
  logic        page;
  logic        blink_on;

  int total = 0;
  int bad   = 0;

  seg_disp_ctrl #(
    .PAGE_CYCLES (8),
    .BLINK_CYCLES(4),
    .BLANK_CODE  (4'hF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_bcd  (time_bcd),
    .time_vld  (time_vld),
    .date_bcd  (date_bcd),
    .date_vld  (date_vld),
    .edit_en   (edit_en),
    .edit_page (edit_page),
    .edit_field(edit_field),
    .seg_bcd   (seg_bcd),
    .page      (page),
    .blink_on  (blink_on)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; time_bcd = '0; time_vld = 1'b0; date_bcd = '0; date_vld = 1'b0;
    edit_en = 1'b0; edit_page = 1'b0; edit_field = 2'd0;

    // e1..e2: reset
    tick_n(2);
    chk("rst_seg", seg_bcd, 24'h000000);
    chk("rst_page", {23'd0, page}, 24'd0);
    chk("rst_blink", {23'd0, blink_on}, 24'd0);

    rst = 1'b0; time_vld = 1'b1; time_bcd = 24'h123456;
    tick();                                   // e3: snapshot loads
    time_vld = 1'b0;
    chk("time_lat1", seg_bcd, 24'h000000);
    tick();                                   // e4
    chk("time_lat2", seg_bcd, 24'h123456);
    chk("time_page", {23'd0, page}, 24'd0);

    date_vld = 1'b1; date_bcd = 24'h250614;
    tick();                                   // e5
    date_vld = 1'b0;
    tick_n(5);                                // e10: last time-page output
    chk("dwell_t_end", {23'd0, page}, 24'd0);
    tick();                                   // e11
    chk("date_page", {23'd0, page}, 24'd1);
    chk("date_seg", seg_bcd, 24'h250614);
    tick_n(7);                                // e18
    chk("dwell_d_end", {23'd0, page}, 24'd1);
    tick();                                   // e19
    chk("back_time_pg", {23'd0, page}, 24'd0);
    chk("back_time_seg", seg_bcd, 24'h123456);

    // edit hh:MM:ss on the time page
    edit_en = 1'b1; edit_page = 1'b0; edit_field = 2'd1;
    tick();                                   // e20
    chk("edit_entry", seg_bcd, 24'h123456);
    for (int k = 0; k < 12; k++) begin        // e21..e32
      tick();
      chk("blink_seg", seg_bcd, ((k / 4) % 2 == 1) ? 24'h12FF56 : 24'h123456);
      chk("blink_flag", {23'd0, blink_on}, ((k / 4) % 2 == 1) ? 24'd1 : 24'd0);
    end
    tick();                                   // e33
    chk("blanked_f1", seg_bcd, 24'h12FF56);

    edit_field = 2'd2;
    tick();                                   // e34
    chk("restart_seg", seg_bcd, 24'h123456);
    chk("restart_blink", {23'd0, blink_on}, 24'd0);
    tick_n(4);                                // e38
    chk("restart_vis", seg_bcd, 24'h123456);
    tick();                                   // e39
    chk("f2_blank_seg", seg_bcd, 24'h1234FF);
    chk("f2_blank_flag", {23'd0, blink_on}, 24'd1);

    edit_en = 1'b0; edit_field = 2'd3;
    tick();                                   // e40: SHOW_TIME re-entered
    chk("exit_seg", seg_bcd, 24'h123456);
    tick_n(7);                                // e47: page counter at its last count
    edit_en = 1'b1;
    tick();                                   // e48
    chk("coinc_pg1", {23'd0, page}, 24'd0);
    tick();                                   // e49
    chk("coinc_pg2", {23'd0, page}, 24'd0);
    chk("coinc_seg", seg_bcd, 24'h123456);

    edit_en = 1'b0; edit_page = 1'b1;
    tick();                                   // e50
    chk("exit_date_pg", {23'd0, page}, 24'd1);
    chk("exit_date_seg", seg_bcd, 24'h250614);
    tick_n(8);                                // e58
    chk("exit_dwell_pg", {23'd0, page}, 24'd1);
    tick();                                   // e59
    chk("exit_dwell_end", {23'd0, page}, 24'd0);

    edit_en = 1'b1; edit_page = 1'b0; edit_field = 2'd0;
    tick_n(7);                                // e60 entry, e66 blanked
    chk("f0_blank", seg_bcd, 24'hFF3456);

    rst = 1'b1; time_vld = 1'b1; time_bcd = 24'h999999;
    tick();                                   // e67
    chk("mid_rst_seg", seg_bcd, 24'h000000);
    chk("mid_rst_page", {23'd0, page}, 24'd0);
    chk("mid_rst_blink", {23'd0, blink_on}, 24'd0);
    rst = 1'b0; time_vld = 1'b0; edit_en = 1'b0; edit_field = 2'd3;
    tick_n(2);                                // e69
    chk("rst_discard", seg_bcd, 24'h000000);

    time_vld = 1'b1; time_bcd = 24'h111111; date_vld = 1'b1; date_bcd = 24'h222222;
    tick();                                   // e70
    time_vld = 1'b0; date_vld = 1'b0;
    tick();                                   // e71
    chk("both_time", seg_bcd, 24'h111111);
    edit_en = 1'b1; edit_page = 1'b1;
    tick_n(2);                                // e73
    chk("both_date", seg_bcd, 24'h222222);
    chk("both_page", {23'd0, page}, 24'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
